// File: rtl/gtxe2_comm_refclk_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// gtxe2_comm_refclk_sel_ctrl_pkg : shared FSM states and select-code constants
// Rev 1.0 - initial release
// ============================================================================
package gtxe2_comm_refclk_sel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_PULSE  = 3'd4
  } state_t;

  // Select code 0 never maps to an input; the mux drives a constant 0 for it.
  localparam int c_SEL_RESERVED = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gtxe2_comm_refclk_mux_n.sv
`default_nettype none
// ============================================================================
// gtxe2_comm_refclk_mux_n : combinational N-way refclk mux, code k -> input k-1
// Rev 1.0 - initial release
// ============================================================================
module gtxe2_comm_refclk_mux_n
  import gtxe2_comm_refclk_sel_ctrl_pkg::*;
#(
  parameter int NUM_CLKS  = 7,
  parameter int SEL_WIDTH = 3
) (
  input  logic [NUM_CLKS-1:0]  i_clk,
  input  logic [SEL_WIDTH-1:0] i_sel,
  output logic                 o_clk
);

  logic [NUM_CLKS-1:0] w_hit;

  for (genvar k = 0; k < NUM_CLKS; k++) begin : g_dec
    assign w_hit[k] = (i_sel == SEL_WIDTH'(k + 1));
  end

  assign o_clk = (i_sel == SEL_WIDTH'(c_SEL_RESERVED)) ? 1'b0 : |(w_hit & i_clk);

endmodule
`default_nettype wire

// File: rtl/gtxe2_comm_refclk_sel_ctrl.sv
`default_nettype none
// ============================================================================
// gtxe2_comm_refclk_sel_ctrl : sequenced refclk select (gate, switch, settle, PLL reset)
// Rev 1.0 - initial release
// ============================================================================
module gtxe2_comm_refclk_sel_ctrl
  import gtxe2_comm_refclk_sel_ctrl_pkg::*;
#(
  parameter int NUM_CLKS      = 7,
  parameter int SEL_WIDTH     = 3,
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RST_CYCLES    = 2,
  parameter int INIT_SEL      = 1
) (
  input  logic                 DRPCLK,
  input  logic                 RESET,
  input  logic [NUM_CLKS-1:0]  REFCLK_IN,
  input  logic [SEL_WIDTH-1:0] SEL_REQ,
  input  logic                 SEL_REQ_VALID,
  output logic                 SEL_REQ_READY,
  output logic [SEL_WIDTH-1:0] SEL_CUR,
  output logic                 SEL_ERR,
  output logic                 SWITCH_DONE,
  output logic                 PLL_RESET_REQ,
  output logic                 MUX_CLK_OUT
);

  localparam int CNT_W = $clog2(max3(GATE_CYCLES, SETTLE_CYCLES, RST_CYCLES) + 1);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [SEL_WIDTH-1:0] r_sel_cur, w_sel_cur_nxt;
  logic [SEL_WIDTH-1:0] r_sel_cap, w_sel_cap_nxt;
  logic                 r_sel_err, w_sel_err_nxt;
  logic                 r_switch_done, w_switch_done_nxt;
  logic                 r_gate_en, w_gate_en_nxt;
  logic                 r_pll_req, w_pll_req_nxt;
  logic                 w_sel_clk;

  always_ff @(posedge DRPCLK) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_sel_cur     <= SEL_WIDTH'(INIT_SEL);
      r_sel_cap     <= SEL_WIDTH'(INIT_SEL);
      r_sel_err     <= 1'b0;
      r_switch_done <= 1'b0;
      r_gate_en     <= 1'b1;
      r_pll_req     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sel_cur     <= w_sel_cur_nxt;
      r_sel_cap     <= w_sel_cap_nxt;
      r_sel_err     <= w_sel_err_nxt;
      r_switch_done <= w_switch_done_nxt;
      r_gate_en     <= w_gate_en_nxt;
      r_pll_req     <= w_pll_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_sel_cur_nxt     = r_sel_cur;
    w_sel_cap_nxt     = r_sel_cap;
    w_sel_err_nxt     = 1'b0;
    w_switch_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (SEL_REQ_VALID) begin
          if (SEL_REQ > SEL_WIDTH'(NUM_CLKS)) begin
            w_sel_err_nxt = 1'b1;
          end else if (SEL_REQ == r_sel_cur) begin
            w_switch_done_nxt = 1'b1;
          end else begin
            w_sel_cap_nxt = SEL_REQ;
            w_cnt_nxt     = CNT_W'(GATE_CYCLES);
            w_state_nxt   = ST_GATE;
          end
        end
      end
      ST_GATE: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_SWITCH;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_SWITCH: begin
        w_sel_cur_nxt = r_sel_cap;
        w_cnt_nxt     = CNT_W'(SETTLE_CYCLES);
        w_state_nxt   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt <= CNT_W'(1)) begin
          if (RST_CYCLES > 0) begin
            w_cnt_nxt   = CNT_W'(RST_CYCLES);
            w_state_nxt = ST_PULSE;
          end else begin
            w_switch_done_nxt = 1'b1;
            w_state_nxt       = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_switch_done_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Gate and reset-request are registered from the next state so both stay glitch-free.
    w_gate_en_nxt = !(w_state_nxt inside {ST_GATE, ST_SWITCH, ST_SETTLE});
    w_pll_req_nxt = (w_state_nxt == ST_PULSE);
  end

  gtxe2_comm_refclk_mux_n #(
    .NUM_CLKS  (NUM_CLKS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_mux (
    .i_clk (REFCLK_IN),
    .i_sel (r_sel_cur),
    .o_clk (w_sel_clk)
  );

  assign SEL_REQ_READY = (r_state == ST_IDLE);
  assign SEL_CUR       = r_sel_cur;
  assign SEL_ERR       = r_sel_err;
  assign SWITCH_DONE   = r_switch_done;
  assign PLL_RESET_REQ = r_pll_req;
  assign MUX_CLK_OUT   = r_gate_en & w_sel_clk;

endmodule
`default_nettype wire

// File: tb/tb_gtxe2_comm_refclk_sel_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gtxe2_comm_refclk_sel_ctrl : directed bench over default, 5-input and no-pulse builds
// Rev 1.0 - initial release
// ============================================================================
module tb_gtxe2_comm_refclk_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] refclk0, refclk2;
  logic [4:0] refclk1;
  logic [2:0] req   [3];
  logic       vld   [3];
  logic       ready [3];
  logic [2:0] cur   [3];
  logic       err   [3];
  logic       done  [3];
  logic       pll   [3];
  logic       mux   [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gtxe2_comm_refclk_sel_ctrl u_dut0 (
    .DRPCLK(clk), .RESET(rst), .REFCLK_IN(refclk0), .SEL_REQ(req[0]), .SEL_REQ_VALID(vld[0]),
    .SEL_REQ_READY(ready[0]), .SEL_CUR(cur[0]), .SEL_ERR(err[0]), .SWITCH_DONE(done[0]),
    .PLL_RESET_REQ(pll[0]), .MUX_CLK_OUT(mux[0])
  );

  gtxe2_comm_refclk_sel_ctrl #(.NUM_CLKS(5)) u_dut1 (
    .DRPCLK(clk), .RESET(rst), .REFCLK_IN(refclk1), .SEL_REQ(req[1]), .SEL_REQ_VALID(vld[1]),
    .SEL_REQ_READY(ready[1]), .SEL_CUR(cur[1]), .SEL_ERR(err[1]), .SWITCH_DONE(done[1]),
    .PLL_RESET_REQ(pll[1]), .MUX_CLK_OUT(mux[1])
  );

  gtxe2_comm_refclk_sel_ctrl #(.RST_CYCLES(0)) u_dut2 (
    .DRPCLK(clk), .RESET(rst), .REFCLK_IN(refclk2), .SEL_REQ(req[2]), .SEL_REQ_VALID(vld[2]),
    .SEL_REQ_READY(ready[2]), .SEL_CUR(cur[2]), .SEL_ERR(err[2]), .SWITCH_DONE(done[2]),
    .PLL_RESET_REQ(pll[2]), .MUX_CLK_OUT(mux[2])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns the period index (1 = cycle after accept) of SWITCH_DONE.
  task automatic do_switch(input int d, input logic [2:0] code, output int lat, output logic pll_seen);
    req[d]   = code;
    vld[d]   = 1'b1;
    pll_seen = 1'b0;
    tick();
    vld[d] = 1'b0;
    lat    = 1;
    while (!done[d] && lat < 40) begin
      pll_seen = pll_seen | pll[d];
      tick();
      lat++;
    end
  endtask

  int   lat;
  logic pseen;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 3'd0;
      vld[d] = 1'b0;
    end
    refclk0 = 7'b0000101;
    refclk1 = 5'b00001;
    refclk2 = 7'b0000011;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state on every build
    for (int d = 0; d < 3; d++) begin
      check("rst_cur", cur[d], 3'd1);
      check("rst_rdy", ready[d], 1'b1);
      check("rst_err", err[d], 1'b0);
      check("rst_done", done[d], 1'b0);
      check("rst_pll", pll[d], 1'b0);
      check("rst_mux", mux[d], 1'b1);
    end
    refclk0[0] = 1'b0;
    #1;
    check("rst_mux_follow", mux[0], 1'b0);
    refclk0[0] = 1'b1;

    // Full default sequence to code 3, with an ignored request while settling
    req[0] = 3'd3;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("s2_mux", mux[0], (k >= 14) ? 1 : 0);
      check("s2_cur", cur[0], (k >= 6) ? 3 : 1);
      check("s2_pll", pll[0], (k == 14 || k == 15));
      check("s2_done", done[0], (k == 16));
      check("s2_rdy", ready[0], (k == 16));
      if (k == 8) begin
        req[0] = 3'd4;
        vld[0] = 1'b1;
      end
      if (k == 9) vld[0] = 1'b0;
      tick();
    end
    check("s2_done_end", done[0], 1'b0);
    check("s2_cur_end", cur[0], 3'd3);
    refclk0[2] = 1'b0;
    #1;
    check("s2_mux_follow", mux[0], 1'b0);

    // Switch to 7, then same-code request, then reserved code 0
    refclk0 = 7'b1111111;
    do_switch(0, 3'd7, lat, pseen);
    check("s3_lat7", lat, 16);
    check("s3_pll7", pseen, 1'b1);
    check("s3_cur7", cur[0], 3'd7);
    req[0] = 3'd7;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    check("s3_same_done", done[0], 1'b1);
    check("s3_same_mux", mux[0], 1'b1);
    check("s3_same_pll", pll[0], 1'b0);
    check("s3_same_rdy", ready[0], 1'b1);
    tick();
    check("s3_same_done_off", done[0], 1'b0);
    do_switch(0, 3'd0, lat, pseen);
    check("s3_lat0", lat, 16);
    check("s3_cur0", cur[0], 3'd0);
    check("s3_mux0", mux[0], 1'b0);

    // Out-of-range codes on the 5-input build
    req[1] = 3'd6;
    vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    check("s4_err", err[1], 1'b1);
    check("s4_cur", cur[1], 3'd1);
    check("s4_rdy", ready[1], 1'b1);
    check("s4_done", done[1], 1'b0);
    tick();
    check("s4_err_off", err[1], 1'b0);
    req[1] = 3'd5;
    vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    check("s4_edge_err", err[1], 1'b0);
    check("s4_edge_rdy", ready[1], 1'b0);
    do_switch(1, 3'd7, lat, pseen);
    check("s4_wait5", cur[1], 3'd5);
    do_switch(1, 3'd7, lat, pseen);
    check("s4_err7_lat", lat, 40);
    check("s4_cur7", cur[1], 3'd5);

    // Reset during GATE aborts the sequence
    refclk0 = 7'b0000001;
    req[0] = 3'd3;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    tick();
    check("s6_in_gate", mux[0], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_cur", cur[0], 3'd1);
    check("s6_rdy", ready[0], 1'b1);
    check("s6_mux", mux[0], 1'b1);
    check("s6_done", done[0], 1'b0);
    for (int k = 0; k < 14; k++) begin
      tick();
      check("s6_no_done", done[0], 1'b0);
    end

    // No PLL pulse build: latency 14
    do_switch(2, 3'd2, lat, pseen);
    check("s6b_lat", lat, 14);
    check("s6b_pll", pseen, 1'b0);
    check("s6b_cur", cur[2], 3'd2);
    check("s6b_mux", mux[2], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
